// File: rtl/findmax_pkg.sv
// Shared constants and state encoding for the find-max datapath: memory reader, comparator and
// top-level control.
package findmax_pkg;

  localparam int unsigned DefaultDataW = 16;
  localparam int unsigned DefaultAddrW = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StIssue = ISSUE,
    StDrain = DRAIN,
    StDone  = DONE
  } reader_state_e;

endpackage

// File: rtl/findmax_valid_pipe.sv
// Shift register that carries {valid, last} across the BRAM read latency, so that each strobe
// lines up with its word on douta.
module findmax_valid_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      last_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      last_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      last_q[0]  <= in_valid && in_last;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/findmax_mem_reader.sv
// Read-side initiator for the find-max BRAM: walks an address window and frames the returned
// words with clear/strobe/last/done for the comparator.
module findmax_mem_reader
  import findmax_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] addra,
  output logic              ena,
  input  logic [DATA_W-1:0] douta,
  output logic              clear_max,
  output logic              active_datapath,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] FullWindow = {1'b1, {ADDR_W{1'b0}}};

  reader_state_e   state_q;
  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] issued_q;   // addresses issued so far, including the one on addra
  logic [ADDR_W:0] count_clamped;
  logic            hit_last;
  logic            flush;

  // douta is consumed by the comparator, not by this block.
  logic unused_douta;
  assign unused_douta = ^douta;

  always_comb begin
    count_clamped = (count > FullWindow) ? FullWindow : count;
    hit_last      = (issued_q == count_q);
    flush         = abort && (state_q == StIssue || state_q == StDrain);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      issued_q  <= '0;
      addra     <= '0;
      ena       <= 1'b0;
      clear_max <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      clear_max <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            count_q <= count_clamped;
            if (count_clamped == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q   <= StIssue;
              addra     <= base_addr;
              issued_q  <= (ADDR_W+1)'(1);
              ena       <= 1'b1;
              clear_max <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (abort) begin
            state_q <= StIdle;
            ena     <= 1'b0;
            busy    <= 1'b0;
          end else if (hit_last) begin
            state_q <= StDrain;
            ena     <= 1'b0;
          end else begin
            addra    <= addra + ADDR_W'(1);
            issued_q <= issued_q + (ADDR_W+1)'(1);
          end
        end
        StDrain: begin
          if (abort) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (active_datapath && last) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  findmax_valid_pipe #(
    .DEPTH(RD_LAT)
  ) u_valid_pipe (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (ena),
    .in_last  (ena && hit_last),
    .out_valid(active_datapath),
    .out_last (last)
  );

endmodule

// File: tb/tb_findmax_mem_reader.sv
// Randomised bench: two readers (RD_LAT 1 and 2) share stimulus and are checked per cycle against
// a schedule-based reference model, plus a comparator model that checks the max at done.
module tb_findmax_mem_reader;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int N = 2000;

  typedef struct packed {
    logic          clr;
    logic          ena;
    logic [AW-1:0] addr;
    logic          act;
    logic          last;
    logic          busy;
    logic          done;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;

  logic [AW-1:0] addra [2];
  logic          ena [2];
  logic          clear_max [2];
  logic          act [2];
  logic          last [2];
  logic          busy [2];
  logic          done [2];
  logic [DW-1:0] douta [2];
  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] r1, r2;
    findmax_mem_reader #(
      .DATA_W(DW),
      .ADDR_W(AW),
      .RD_LAT(32'(g + 1))
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .base_addr      (base_addr),
      .count          (count),
      .addra          (addra[g]),
      .ena            (ena[g]),
      .douta          (douta[g]),
      .clear_max      (clear_max[g]),
      .active_datapath(act[g]),
      .last           (last[g]),
      .busy           (busy[g]),
      .done           (done[g])
    );
    // Behavioural BRAM with read latency g+1.
    always @(posedge clk) begin
      if (ena[g]) r1 <= mem[addra[g]];
      r2 <= r1;
    end
    assign douta[g] = (g == 0) ? r1 : r2;
  end

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  out_t exp_q [2][N];
  int   exp_max [2][N];
  int   idle_from [2];
  int   scan_t [2];
  int   scan_end [2];
  bit   scanning [2];
  int   mx [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic out_t dut_out(input int l);
    out_t o;
    o.clr  = clear_max[l];
    o.ena  = ena[l];
    o.addr = ena[l] ? addra[l] : '0;
    o.act  = act[l];
    o.last = last[l];
    o.busy = busy[l];
    o.done = done[l];
    return o;
  endfunction

  // Expected trace of a scan accepted at edge t: address i after edge t+i, its word after
  // edge t+i+L, done after edge t+n+L.
  task automatic schedule(input int l, input int t, input int n, input int b);
    int L;
    int m;
    L = l + 1;
    if (n == 0) begin
      exp_q[l][t].done = 1'b1;
      idle_from[l] = t + 2;
      scanning[l] = 1'b0;
      return;
    end
    m = 0;
    exp_q[l][t].clr = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q[l][t+i].ena  = 1'b1;
      exp_q[l][t+i].addr = AW'((b + i) % 16);
      exp_q[l][t+i+L].act  = 1'b1;
      exp_q[l][t+i+L].last = (i == n - 1);
      if (int'(mem[(b + i) % 16]) > m) m = int'(mem[(b + i) % 16]);
    end
    for (int k = t; k < t + n + L; k++) exp_q[l][k].busy = 1'b1;
    exp_q[l][t+n+L].done = 1'b1;
    exp_max[l][t+n+L] = m;
    scan_t[l] = t;
    scan_end[l] = t + n + L;
    scanning[l] = 1'b1;
    idle_from[l] = t + n + L + 2;
  endtask

  task automatic cancel(input int l, input int from);
    for (int k = from; k <= scan_end[l]; k++) begin
      exp_q[l][k] = '0;
      exp_max[l][k] = -1;
    end
    scanning[l] = 1'b0;
  endtask

  task automatic model_edge(input int e);
    int n;
    for (int l = 0; l < 2; l++) begin
      if (scanning[l] && e > scan_end[l]) scanning[l] = 1'b0;
      if (!reset) continue;
      if (start && e >= idle_from[l]) begin
        n = (int'(count) > 16) ? 16 : int'(count);
        schedule(l, e, n, int'(base_addr));
      end else if (abort && scanning[l] && e > scan_t[l]) begin
        cancel(l, e);
        idle_from[l] = e + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge(cyc);
    #1;
    for (int l = 0; l < 2; l++) begin
      check_eq($sformatf("lat%0d_out@%0d", l + 1, cyc), 32'(dut_out(l)), 32'(exp_q[l][cyc]));
      if (clear_max[l]) mx[l] = 0;
      if (act[l] && int'(douta[l]) > mx[l]) mx[l] = int'(douta[l]);
      if (exp_max[l][cyc] >= 0)
        check_eq($sformatf("lat%0d_max@%0d", l + 1, cyc), 32'(mx[l]), 32'(exp_max[l][cyc]));
    end
  endtask

  task automatic idle_wait();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (cyc + 1 >= idle_from[0] && cyc + 1 >= idle_from[1]) break;
      step();
    end
  endtask

  task automatic do_start(input int b, input int n);
    start = 1'b1;
    base_addr = AW'(b);
    count = (AW+1)'(n);
    step();
    start = 1'b0;
    base_addr = AW'($urandom);
    count = (AW+1)'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    for (int l = 0; l < 2; l++)
      check_eq($sformatf("%s_lat%0d", tag, l + 1), 32'(dut_out(l)), 32'(0));
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < N; k++) begin
        exp_q[l][k] = '0;
        exp_max[l][k] = -1;
      end
      idle_from[l] = 1 << 30;
      scanning[l] = 1'b0;
      mx[l] = 0;
    end
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    mem[0] = 16'd3; mem[1] = 16'd9; mem[2] = 16'd2; mem[3] = 16'd7;

    #3;
    check_all_zero("reset");
    step(); step();
    reset = 1'b1;
    idle_from[0] = cyc + 1;
    idle_from[1] = cyc + 1;
    step();

    do_start(0, 4);  idle_wait();
    do_start(0, 0);  idle_wait();
    do_start(14, 4); idle_wait();
    do_start(5, 3);  idle_wait();

    // Abort after the third address, with an ignored start pulsed mid-scan.
    do_start(0, 8);
    step();
    start = 1'b1; base_addr = 4'd9; count = 5'd1;
    step();
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    idle_wait();
    do_start(2, 2);  idle_wait();

    do_start(0, 16); idle_wait();
    do_start(0, 20); idle_wait();

    // Asynchronous reset in the middle of a full-window scan.
    do_start(3, 16);
    step(); step(); step();
    #2 reset = 1'b0;
    #1 check_all_zero("midreset");
    for (int l = 0; l < 2; l++) begin
      for (int k = cyc + 1; k < cyc + 40; k++) begin
        exp_q[l][k] = '0;
        exp_max[l][k] = -1;
      end
      scanning[l] = 1'b0;
      idle_from[l] = 1 << 30;
    end
    start = 1'b1;
    step(); step();
    start = 1'b0;
    step();
    reset = 1'b1;
    idle_from[0] = cyc + 1;
    idle_from[1] = cyc + 1;
    step(); step(); step();
    do_start(1, 5); idle_wait();

    for (int k = 0; k < 600; k++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 15) == 0);
      base_addr = AW'($urandom);
      count = (AW+1)'($urandom_range(0, 20));
      step();
    end
    idle_wait();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/findmax_mem_reader.md
Name: findmax_mem_reader

Overview:
- Read-side initiator that drives the block RAM feeding the find-max comparator.
- On a start request it sequences addresses through a contiguous window of memory and accounts for the BRAM read latency.
- Emits the per-word datapath-enable strobe aligned with douta, plus clear/last/done framing, so the comparator sees exactly one valid word per strobe.
- Sits between the top-level control FSM and the memory/comparator pair.

Parameters:
DATA_W, 16, width of memory words (douta); passed through for framing only.
ADDR_W, 4, BRAM address width; window addresses wrap modulo 2^ADDR_W.
RD_LAT, 1, BRAM read latency in cycles (legal 1..3), from addra/ena to valid douta.

Ports:
clk  in  1  single clock, all logic rising-edge.
reset  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
start  in  1  scan request; sampled only in IDLE.
abort  in  1  cancels an active scan; ignored in IDLE/DONE.
base_addr  in  ADDR_W  first address of the window; latched on accepted start.
count  in  ADDR_W+1  number of words to scan; latched on accepted start.
addra  out  ADDR_W  BRAM address, registered.
ena  out  1  BRAM read enable, registered.
douta  in  DATA_W  BRAM read data (not registered here; monitored only by the bench).
clear_max  out  1  one-cycle pulse telling the comparator to zero its max.
active_datapath  out  1  high exactly in cycles where douta holds a requested word.
last  out  1  high with active_datapath on the final word of the window.
busy  out  1  high from the cycle after accepted start until the cycle before done.
done  out  1  one-cycle completion pulse; not raised on abort.

Behaviour:
- Reset (reset=0, async): state=IDLE; addra=0, ena=0, clear_max=0, active_datapath=0, last=0, busy=0, done=0; latency pipeline cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start=1 at edge t:
  - Latch base_addr and count. A count above 2^ADDR_W is clamped to 2^ADDR_W.
  - If count==0: go to DONE. done=1 in cycle t+1; no ena, no clear_max.
  - Otherwise: go to ISSUE. clear_max=1 and busy=1 in cycle t+1.
- ISSUE:
  - ena=1 every cycle. addra = (base + i) mod 2^ADDR_W, for i = 0..count-1 on consecutive cycles. The first address appears in cycle t+1 (same cycle as clear_max).
  - After issuing i=count-1, go to DRAIN; ena=0 from the next cycle.
- Valid pipeline: an RD_LAT-deep shift register carries (valid, last_tag) from ena.
  - Address issued in cycle k gives active_datapath=1 in cycle k+RD_LAT.
  - last=1 accompanies the word with i=count-1.
  - No bubbles: count words produce exactly count consecutive strobe cycles.
- DRAIN: wait until the pipeline is empty (the last strobe cycle has passed), then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE.
  - done rises in the cycle immediately after the last strobe cycle.
- start while in ISSUE, DRAIN or DONE: ignored, with no effect on state or latched values.
- abort=1 in ISSUE or DRAIN, sampled at edge a:
  - From cycle a+1: ena=0, pipeline flushed, active_datapath=0, busy=0; state=IDLE; no done pulse.
  - A new start is accepted from edge a+1 onward.
- start and abort high together in IDLE: start wins, because abort is ignored in IDLE.
- Reset asserted mid-scan: all outputs drop asynchronously. After release the block waits in IDLE for a fresh start.
- Full window (count=2^ADDR_W): every address is read once; the counter must not alias to 0.

Decomposition:
- Shared package findmax_pkg holds:
  - state encoding localparams (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, DONE=2'd3);
  - default DATA_W=16 and ADDR_W=4 constants shared with the comparator and top level.
- One natural sub-module: findmax_valid_pipe, an RD_LAT-deep shift register of {valid,last} with synchronous flush and async active-low reset.

Test Plan:
1. ADDR_W=4, RD_LAT=1, mem[0..3]={3,9,2,7}; start with base=0, count=4.
   - addra 0,1,2,3 with ena=1 on 4 consecutive cycles.
   - active_datapath high 4 cycles starting 1 cycle later; last on the word 7.
   - done one cycle after last; comparator max=9.
2. count=0 -> no ena, no clear_max, no active_datapath; done=1 exactly one cycle after start; busy stays 0.
3. base=14, count=4 -> addra sequence 14,15,0,1; 4 strobes; done once.
4. RD_LAT=2, base=5, count=3 -> strobes lag ena by 2 cycles; last on the word from address 7; done the cycle after that strobe.
5. Abort and start-while-busy:
   - base=0, count=8, abort after the 3rd address -> ena low next cycle; at most RD_LAT strobes suppressed (none after abort); no done.
   - A following start (base=2, count=2) completes normally.
   - A start pulsed mid-scan is ignored.
6. count=16 (full window) -> 16 addresses 0..15 and 16 strobes. Then reset asserted during ISSUE in a second scan -> all outputs 0 immediately; after release, outputs stay idle until the next start.
